sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_if.sv | 29 ++
 rtl/sram_controller.sv | 182 ++++++++++++++++++
 tb/tb_sram_controller.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// ---------------------------------------------------------------------------
// sram_controller_if
// Pipeline-side request/response bundle for the data-memory SRAM controller.
//   wr_en      : store request from the EXE/MEM register
//   rd_en      : load request from the EXE/MEM register
//   address    : byte address (ALU result), word aligned
//   write_data : store data (Rm value)
//   read_data  : last completed load word
//   ready      : low while an access is in progress (freeze = ~ready)
// The pipeline side uses the master modport, the controller the slave one.
// ---------------------------------------------------------------------------
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
// Splits each 32-bit load/store from the pipeline into two 16-bit SRAM
// half-accesses (low half first, then high half), each held for WAIT_CYCLES
// clocks, followed by a single DONE cycle in which ready is asserted.
//
// Parameters
//   WAIT_CYCLES : clocks per half-access, 1..15
//   BASE_ADDR   : data-memory base subtracted from the ALU byte address
// Ports
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : pipeline request/response bundle (slave side)
//   sram_addr   : SRAM halfword address {word, half}
//   sram_dq_out : SRAM write data
//   sram_dq_in  : SRAM read data
//   sram_dq_oe  : 1 = controller drives the SRAM data bus
//   sram_we_n   : SRAM write strobe, active low
// ---------------------------------------------------------------------------
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic                    clk,
  input  logic                    rst,
  sram_controller_if.slave        bus,
  output logic [17:0]             sram_addr,
  output logic [15:0]             sram_dq_out,
  input  logic [15:0]             sram_dq_in,
  output logic                    sram_dq_oe,
  output logic                    sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_e;

  // Terminal value of the per-phase wait counter.
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_e      state_q,     state_d;
  logic [3:0]  wait_cnt_q,  wait_cnt_d;
  logic        op_q,        op_d;          // 1 = write
  logic [16:0] word_q,      word_d;
  logic [31:0] wdata_q,     wdata_d;
  logic [31:0] read_data_q, read_data_d;
  logic [17:0] sram_addr_q, sram_addr_d;
  logic [15:0] dq_out_q,    dq_out_d;
  logic        dq_oe_q,     dq_oe_d;
  logic        we_n_q,      we_n_d;

  logic        req_s;
  logic        wait_last_s;
  logic        ready_s;
  logic [31:0] offset_s;
  logic [16:0] req_word_s;
  logic        unused_offset_s;

  assign req_s       = bus.wr_en | bus.rd_en;
  assign offset_s    = bus.address - BASE_ADDR;
  assign req_word_s  = offset_s[18:2];
  // Byte-lane bits and the part above the 18-bit halfword space are dropped.
  assign unused_offset_s = ^{offset_s[31:19], offset_s[1:0]};
  assign wait_last_s = (wait_cnt_q == WAIT_LAST);

  // Next-state, SRAM pin and read-capture logic.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    op_d        = op_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    we_n_d      = we_n_q;
    ready_s     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_s) begin
          // Pins are loaded straight from the inputs so the low half is
          // already valid on the first LOW cycle; a write wins over a read.
          state_d     = LOW;
          wait_cnt_d  = 4'd0;
          op_d        = bus.wr_en;
          word_d      = req_word_s;
          wdata_d     = bus.write_data;
          sram_addr_d = {req_word_s, 1'b0};
          dq_out_d    = bus.write_data[15:0];
          dq_oe_d     = bus.wr_en;
          we_n_d      = ~bus.wr_en;
          ready_s     = 1'b0;
        end else begin
          ready_s     = 1'b1;
        end
      end

      LOW: begin
        if (wait_last_s) begin
          state_d     = HIGH;
          wait_cnt_d  = 4'd0;
          sram_addr_d = {word_q, 1'b1};
          dq_out_d    = wdata_q[31:16];
          if (!op_q) begin
            read_data_d = {read_data_q[31:16], sram_dq_in};
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          wait_cnt_d  = wait_cnt_q + 4'd1;
        end
      end

      HIGH: begin
        if (wait_last_s) begin
          state_d    = DONE;
          wait_cnt_d = 4'd0;
          dq_oe_d    = 1'b0;
          we_n_d     = 1'b1;
          if (!op_q) begin
            read_data_d = {sram_dq_in, read_data_q[15:0]};
          end else begin
            read_data_d = read_data_q;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        ready_s = 1'b1;
      end

      default: begin
        state_d = IDLE;
        dq_oe_d = 1'b0;
        we_n_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 4'd0;
      op_q        <= 1'b0;
      word_q      <= 17'd0;
      wdata_q     <= 32'd0;
      read_data_q <= 32'd0;
      sram_addr_q <= 18'd0;
      dq_out_q    <= 16'd0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      op_q        <= op_d;
      word_q      <= word_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.ready     = ready_s;
  assign sram_addr     = sram_addr_q;
  assign sram_dq_out   = dq_out_q;
  assign sram_dq_oe    = dq_oe_q;
  assign sram_we_n     = we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
// Randomized scoreboard bench for sram_controller. The driver computes the
// expected outcome of each access from a word-level memory model and pushes
// it into a queue; an independent monitor pops an entry whenever the
// controller starts an access and checks the SRAM pins phase by phase, the
// latency and read_data when ready returns. A second instance with
// WAIT_CYCLES = 1 covers the short-latency case.
// ---------------------------------------------------------------------------
module tb_sram_controller;

  localparam int unsigned W    = 2;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    int          word;
    logic [31:0] data;
    bit          wr;
    logic [31:0] exp_rd;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_controller_if bus_if();
  sram_controller_if bus1_if();

  logic [17:0] sram_addr,   sram_addr1;
  logic [15:0] sram_dq_out, sram_dq_out1;
  logic [15:0] sram_dq_in;
  logic [15:0] sram_dq_in1;
  logic        sram_dq_oe,  sram_dq_oe1;
  logic        sram_we_n,   sram_we_n1;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(BASE)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1_if),
    .sram_addr(sram_addr1), .sram_dq_out(sram_dq_out1), .sram_dq_in(sram_dq_in1),
    .sram_dq_oe(sram_dq_oe1), .sram_we_n(sram_we_n1)
  );

  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];
  bit   mon_busy = 1'b0;

  logic [31:0] ref_mem [int];
  logic [31:0] last_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-on content of the external SRAM, per halfword.
  function automatic logic [15:0] init_half(input int h);
    logic [31:0] v;
    v = h * 32'h9E3779B1 + 32'h1F3A5C07;
    return v[31:16];
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'(((addr - BASE) >> 2) % 32'd131072);
  endfunction

  function automatic logic [31:0] ref_read(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return {init_half(2 * w + 1), init_half(2 * w)};
  endfunction

  // Asynchronous-read SRAM model: writes on a rising edge with we_n low.
  initial begin : sram_model
    logic [15:0] mem [int];
    sram_dq_in  = 16'h0000;
    sram_dq_in1 = 16'h5A5A;
    forever begin
      @(posedge clk);
      if (!sram_we_n) mem[int'(sram_addr)] = sram_dq_out;
      #1;
      sram_dq_in = mem.exists(int'(sram_addr)) ? mem[int'(sram_addr)]
                                               : init_half(int'(sram_addr));
    end
  end

  // Monitor: pops the expected access when ready drops and follows it.
  initial begin : monitor
    txn_t        cur;
    int          idx;
    logic [17:0] lo_a;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy = 1'b0;
      end else if (!mon_busy && !bus_if.ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access: ready low with no queued request at %0t", $time);
          mon_busy = 1'b1;
          cur = '{word: 0, data: 32'd0, wr: 1'b0, exp_rd: 32'd0};
        end else begin
          cur = exp_q.pop_front();
          mon_busy = 1'b1;
        end
        idx = 0;
        check("req_cycle_we_oe", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
      end else if (mon_busy && !bus_if.ready) begin
        idx++;
        lo_a = 18'(cur.word * 2);
        if (idx <= int'(W)) begin
          check("low_addr", 64'(sram_addr), 64'(lo_a));
          check("low_dq_out", 64'(sram_dq_out), 64'(cur.data[15:0]));
        end else begin
          check("high_addr", 64'(sram_addr), 64'(lo_a + 18'd1));
          check("high_dq_out", 64'(sram_dq_out), 64'(cur.data[31:16]));
        end
        check("phase_we_oe", 64'({sram_we_n, sram_dq_oe}), cur.wr ? 64'(2'b01) : 64'(2'b10));
      end else if (mon_busy && bus_if.ready) begin
        idx++;
        lo_a = 18'(cur.word * 2);
        check("latency", 64'(idx), 64'(2 * W + 1));
        check("read_data", 64'(bus_if.read_data), 64'(cur.exp_rd));
        check("done_we_oe", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
        check("done_addr_hold", 64'(sram_addr), 64'(lo_a + 18'd1));
        mon_busy = 1'b0;
      end else begin
        check("idle_we_oe", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
      end
    end
  end

  // Issues one access at posedge+1 (controller in IDLE or DONE) and returns
  // in its DONE cycle. From DONE one extra IDLE cycle precedes the access.
  task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [31:0] data, input bit from_done);
    txn_t t;
    int   n;
    t.word = word_of(addr);
    t.data = data;
    t.wr   = wr;
    if (wr) begin
      ref_mem[t.word] = data;
      t.exp_rd = last_rd;
    end else begin
      t.exp_rd = ref_read(t.word);
      last_rd  = t.exp_rd;
    end
    exp_q.push_back(t);
    bus_if.wr_en      = wr;
    bus_if.rd_en      = rd;
    bus_if.address    = addr;
    bus_if.write_data = data;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus_if.ready && n < 60);
    if (!bus_if.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready still 0 after %0d cycles", n);
    end else begin
      check("driver_latency", 64'(n), from_done ? 64'(2 * W + 2) : 64'(2 * W + 1));
    end
  endtask

  task automatic idle(input int n);
    bus_if.wr_en = 1'b0;
    bus_if.rd_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : main
    logic [31:0] a;
    logic [31:0] d;
    int          op;
    int          gap;
    bit          from_done;
    int          n;

    rst                 = 1'b1;
    last_rd             = 32'd0;
    bus_if.wr_en        = 1'b0;
    bus_if.rd_en        = 1'b0;
    bus_if.address      = 32'd0;
    bus_if.write_data   = 32'd0;
    bus1_if.wr_en       = 1'b0;
    bus1_if.rd_en       = 1'b0;
    bus1_if.address     = 32'd0;
    bus1_if.write_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_ready", 64'(bus_if.ready), 64'd1);
    check("rst_read_data", 64'(bus_if.read_data), 64'd0);
    check("rst_sram_addr", 64'(sram_addr), 64'd0);
    check("rst_dq_out", 64'(sram_dq_out), 64'd0);
    check("rst_we_oe", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));

    repeat (10) begin
      @(posedge clk);
      #1;
      check("idle_ready", 64'(bus_if.ready), 64'd1);
    end

    // Directed: write, rewrite and back-to-back read of the same word.
    issue(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 1'b0);
    issue(1'b1, 1'b0, 32'd1032, 32'hABCD1234, 1'b1);
    issue(1'b0, 1'b1, 32'd1032, 32'h0000_0000, 1'b1);
    check("directed_read", 64'(bus_if.read_data), 64'h0000_0000_ABCD_1234);
    idle(2);
    // Both enables: behaves as a write, read_data untouched.
    issue(1'b1, 1'b1, BASE + 32'd8, 32'h55AA0FF0, 1'b0);
    check("both_keeps_read", 64'(bus_if.read_data), 64'h0000_0000_ABCD_1234);
    idle(1);

    // Reset during the last HIGH cycle of a write.
    a = BASE + 32'd12;
    d = $urandom;
    begin
      txn_t t;
      t = '{word: word_of(a), data: d, wr: 1'b1, exp_rd: last_rd};
      ref_mem[t.word] = d;
      exp_q.push_back(t);
    end
    bus_if.wr_en      = 1'b1;
    bus_if.rd_en      = 1'b0;
    bus_if.address    = a;
    bus_if.write_data = d;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
    end
    check("pre_abort_we_n", 64'(sram_we_n), 64'd0);
    rst          = 1'b1;
    bus_if.wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_rd = 32'd0;
    check("abort_ready", 64'(bus_if.ready), 64'd1);
    check("abort_we_oe", 64'({sram_we_n, sram_dq_oe}), 64'(2'b10));
    check("abort_read_data", 64'(bus_if.read_data), 64'd0);
    idle(1);

    // Randomized traffic with random gaps, including back-to-back.
    from_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) a = $urandom & 32'hFFFF_FFFC;
      else a = BASE + 32'(4 * $urandom_range(0, 15));
      d = $urandom;
      issue(op != 1, op != 0, a, d, from_done);
      gap = int'($urandom_range(0, 3));
      if (gap == 0) begin
        from_done = 1'b1;
      end else begin
        idle(gap);
        from_done = 1'b0;
      end
    end
    idle(2);

    // Short-latency instance.
    bus1_if.rd_en   = 1'b1;
    bus1_if.address = BASE;
    #1;
    check("w1_req_ready", 64'(bus1_if.ready), 64'd0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus1_if.ready && n < 20);
    check("w1_latency", 64'(n), 64'd3);
    check("w1_read_data", 64'(bus1_if.read_data), 64'h0000_0000_5A5A_5A5A);
    bus1_if.rd_en = 1'b0;
    idle(3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("monitor_idle", 64'(mon_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
